// File: rtl/dpd_pkg.sv
// Shared DPD definitions: default widths, sample/gain types and the
// round-half-up + clamp helper used by the output conditioning stage.
package dpd_pkg;

  localparam int DPD_DATA_WIDTH = 16;
  localparam int DPD_GAIN_WIDTH = 16;
  localparam int DPD_FRAC_SZ    = 12;

  typedef logic signed [DPD_DATA_WIDTH-1:0] data_t;
  typedef logic signed [DPD_GAIN_WIDTH-1:0] gain_t;

  // Result of scaling one product: clamped value plus a "was clamped" flag.
  // The value is carried at 64 bits so the helper serves any width <= 64.
  typedef struct packed {
    logic               sat;
    logic signed [63:0] val;
  } sat_res_t;

  // Add half an LSB, arithmetic-shift by frac, clamp to a signed dw-bit range.
  function automatic sat_res_t sat_f(input logic signed [63:0] p,
                                     input int                 frac,
                                     input int                 dw);
    sat_res_t           res;
    logic signed [63:0] rnd;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    rnd = (p + (64'sd1 <<< (frac - 1))) >>> frac;
    hi  = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (dw - 1));
    if (rnd > hi) begin
      res.sat = 1'b1;
      res.val = hi;
    end else if (rnd < lo) begin
      res.sat = 1'b1;
      res.val = lo;
    end else begin
      res.sat = 1'b0;
      res.val = rnd;
    end
    return res;
  endfunction

endpackage

// File: rtl/dpd_sync_fifo.sv
// First-word-fall-through synchronous FIFO. The head entry is visible
// combinationally; a write while full is accepted when a read happens in
// the same cycle (the freed slot is the one being written).
module dpd_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_rd;
  logic             w_do_wr;

  // Flags, level, head data and qualified read/write strobes.
  always_comb begin
    o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
              (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    o_empty = (r_wr_ptr == r_rd_ptr);
    o_level = r_wr_ptr - r_rd_ptr;
    o_rdata = r_mem[r_rd_ptr[AW-1:0]];
    w_do_rd = i_rd && !o_empty;
    w_do_wr = i_wr && (!o_full || w_do_rd);
  end

  // Pointer advance; pointers carry one extra bit to tell full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage; cleared on reset so no stale sample can ever reach the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= {WIDTH{1'b0}};
    end else if (w_do_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

endmodule

// File: rtl/dpd_output_stage.sv
// DPD output conditioning: back-off gain multiply, round-half-up + clamp,
// FWFT buffering toward the DAC with ready/valid, and status reporting.
module dpd_output_stage
  import dpd_pkg::*;
#(
  parameter int DATA_WIDTH   = DPD_DATA_WIDTH,
  parameter int GAIN_WIDTH   = DPD_GAIN_WIDTH,
  parameter int FRAC_SZ      = DPD_FRAC_SZ,
  parameter int FIFO_AW      = 4,
  parameter int SATCNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ENABLE,
  input  logic                          valid_in,
  input  logic signed [DATA_WIDTH-1:0]  y_in_re,
  input  logic signed [DATA_WIDTH-1:0]  y_in_im,
  input  logic signed [GAIN_WIDTH-1:0]  gain,
  input  logic                          clr_status,
  input  logic                          dac_ready,
  output logic                          dac_valid,
  output logic signed [DATA_WIDTH-1:0]  dac_re,
  output logic signed [DATA_WIDTH-1:0]  dac_im,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [FIFO_AW:0]              fifo_level,
  output logic                          overflow,
  output logic [SATCNT_WIDTH-1:0]       sat_count
);

  localparam int PW = DATA_WIDTH + GAIN_WIDTH;

  logic                         r_s1_valid;
  logic signed [PW-1:0]         r_p_re;
  logic signed [PW-1:0]         r_p_im;
  logic                         r_s2_valid;
  logic signed [DATA_WIDTH-1:0] r_s2_re;
  logic signed [DATA_WIDTH-1:0] r_s2_im;
  logic                         r_s2_sat;
  logic                         r_overflow;
  logic [SATCNT_WIDTH-1:0]      r_sat_count;

  sat_res_t                     w_sat_re;
  sat_res_t                     w_sat_im;
  logic                         w_accept;
  logic                         w_rd;
  logic                         w_wr;
  logic [2*DATA_WIDTH-1:0]      w_head;

  // S1: full-width products of the accepted sample and its gain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_p_re     <= {PW{1'b0}};
      r_p_im     <= {PW{1'b0}};
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_p_re <= PW'(y_in_re) * PW'(gain);
        r_p_im <= PW'(y_in_im) * PW'(gain);
      end
    end
  end

  // Sample acceptance, scaling of the S1 products, FIFO handshake terms.
  always_comb begin
    w_accept = valid_in && ENABLE;
    w_sat_re = sat_f(64'(r_p_re), FRAC_SZ, DATA_WIDTH);
    w_sat_im = sat_f(64'(r_p_im), FRAC_SZ, DATA_WIDTH);
    w_rd     = dac_valid && dac_ready;
    w_wr     = r_s2_valid && (!fifo_full || w_rd);
  end

  // S2: register rounded/clamped sample and its saturation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_re    <= {DATA_WIDTH{1'b0}};
      r_s2_im    <= {DATA_WIDTH{1'b0}};
      r_s2_sat   <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_re  <= DATA_WIDTH'(w_sat_re.val);
        r_s2_im  <= DATA_WIDTH'(w_sat_im.val);
        r_s2_sat <= w_sat_re.sat | w_sat_im.sat;
      end
    end
  end

  // Status: saturating event counter and sticky drop flag; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_count <= {SATCNT_WIDTH{1'b0}};
      r_overflow  <= 1'b0;
    end else if (clr_status) begin
      r_sat_count <= {SATCNT_WIDTH{1'b0}};
      r_overflow  <= 1'b0;
    end else begin
      if (r_s2_valid && r_s2_sat && (r_sat_count != {SATCNT_WIDTH{1'b1}}))
        r_sat_count <= r_sat_count + {{(SATCNT_WIDTH-1){1'b0}}, 1'b1};
      if (r_s2_valid && !w_wr)
        r_overflow <= 1'b1;
    end
  end

  dpd_sync_fifo #(
    .WIDTH (2*DATA_WIDTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr    (w_wr),
    .i_wdata ({r_s2_re, r_s2_im}),
    .i_rd    (w_rd),
    .o_rdata (w_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (fifo_level)
  );

  // DAC-side view of the FIFO head; data forced to zero when not valid.
  always_comb begin
    dac_valid = !fifo_empty;
    if (dac_valid) begin
      dac_re = w_head[2*DATA_WIDTH-1:DATA_WIDTH];
      dac_im = w_head[DATA_WIDTH-1:0];
    end else begin
      dac_re = {DATA_WIDTH{1'b0}};
      dac_im = {DATA_WIDTH{1'b0}};
    end
    overflow  = r_overflow;
    sat_count = r_sat_count;
  end

endmodule

// File: tb/tb_dpd_output_stage.sv
// Scoreboard bench for dpd_output_stage: the stimulus side computes each
// expected scaled sample when it is issued; a negedge monitor tracks what
// the buffer should hold and compares the DAC side and status every cycle.
module tb_dpd_output_stage;

  logic               clk;
  logic               rst_n;
  logic               ENABLE;
  logic               valid_in;
  logic signed [15:0] y_in_re;
  logic signed [15:0] y_in_im;
  logic signed [15:0] gain;
  logic               clr_status;
  logic               dac_ready;
  logic               dac_valid;
  logic signed [15:0] dac_re;
  logic signed [15:0] dac_im;
  logic               fifo_full;
  logic               fifo_empty;
  logic [4:0]         fifo_level;
  logic               overflow;
  logic [15:0]        sat_count;

  typedef struct {
    longint re;
    longint im;
    bit     sat;
  } smp_t;

  smp_t iss_q[$];   // expected results, pushed at issue time
  smp_t fq[$];      // expected buffer contents (head first)
  smp_t m1, m2;     // samples in flight toward the buffer
  bit   m1v, m2v;
  int   m_sat;
  bit   m_ovf;

  int checks   = 0;
  int failures = 0;

  dpd_output_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ENABLE     (ENABLE),
    .valid_in   (valid_in),
    .y_in_re    (y_in_re),
    .y_in_im    (y_in_im),
    .gain       (gain),
    .clr_status (clr_status),
    .dac_ready  (dac_ready),
    .dac_valid  (dac_valid),
    .dac_re     (dac_re),
    .dac_im     (dac_im),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .sat_count  (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // x*g/4096 rounded half up (floor of value+0.5), then clamped to int16.
  function automatic longint scale1(input longint x, input longint g, output bit s);
    longint v, q;
    v = x * g + 2048;
    q = v / 4096;
    if ((v % 4096 != 0) && (v < 0)) q = q - 1;
    s = 1'b0;
    if (q > 32767) begin
      q = 32767;
      s = 1'b1;
    end else if (q < -32768) begin
      q = -32768;
      s = 1'b1;
    end
    return q;
  endfunction

  function automatic smp_t model(input longint xr, input longint xi, input longint g);
    smp_t r;
    bit   sr, si;
    r.re  = scale1(xr, g, sr);
    r.im  = scale1(xi, g, si);
    r.sat = sr | si;
    return r;
  endfunction

  // Drive one cycle of sample input; remaining inputs are set by the caller.
  task automatic issue(input bit v, input int re, input int im);
    valid_in = v;
    y_in_re  = 16'(re);
    y_in_im  = 16'(im);
    if (v && ENABLE) iss_q.push_back(model(y_in_re, y_in_im, gain));
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, 0, 0);
  endtask

  // Monitor: compare DAC side and status, then advance the expected state
  // by the effect of the coming rising edge.
  always @(negedge clk) begin
    bit rd, acc;
    if (!rst_n) begin
      fq.delete();
      iss_q.delete();
      m1v = 1'b0;
      m2v = 1'b0;
      m_sat = 0;
      m_ovf = 1'b0;
      chk("rst_dac_valid", dac_valid, 0);
      chk("rst_dac_re", dac_re, 0);
      chk("rst_fifo_level", fifo_level, 0);
      chk("rst_fifo_empty", fifo_empty, 1);
      chk("rst_fifo_full", fifo_full, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_sat_count", sat_count, 0);
    end else begin
      chk("dac_valid", dac_valid, (fq.size() > 0) ? 1 : 0);
      if (fq.size() > 0) begin
        chk("dac_re", dac_re, fq[0].re);
        chk("dac_im", dac_im, fq[0].im);
      end else begin
        chk("dac_re_idle", dac_re, 0);
        chk("dac_im_idle", dac_im, 0);
      end
      chk("fifo_level", fifo_level, fq.size());
      chk("fifo_full", fifo_full, (fq.size() == 16) ? 1 : 0);
      chk("fifo_empty", fifo_empty, (fq.size() == 0) ? 1 : 0);
      chk("overflow", overflow, m_ovf);
      chk("sat_count", sat_count, m_sat);

      rd  = (fq.size() > 0) && dac_ready;
      acc = 1'b0;
      if (m2v) begin
        if (m2.sat && m_sat != 65535) m_sat++;
        if (fq.size() < 16 || rd) acc = 1'b1;
        else m_ovf = 1'b1;
      end
      if (clr_status) begin
        m_sat = 0;
        m_ovf = 1'b0;
      end
      if (rd) void'(fq.pop_front());
      if (acc) fq.push_back(m2);
      m2v = m1v;
      m2  = m1;
      m1v = 1'b0;
      if (valid_in && ENABLE) begin
        if (iss_q.size() == 0) begin
          chk("issue_queue_nonempty", 0, 1);
        end else begin
          m1  = iss_q.pop_front();
          m1v = 1'b1;
        end
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    ENABLE     = 1'b1;
    valid_in   = 1'b0;
    y_in_re    = 16'sd0;
    y_in_im    = 16'sd0;
    gain       = 16'sd4096;
    clr_status = 1'b0;
    dac_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Unity gain passthrough
    gain = 16'sd4096;
    issue(1'b1, 1000, -1000);
    idle(5);

    // Saturation, counter increments, then clear
    gain = 16'sd8192;
    issue(1'b1, 20000, -20000);
    idle(3);
    issue(1'b1, 30000, 5);
    idle(3);
    clr_status = 1'b1;
    idle(1);
    clr_status = 1'b0;
    idle(2);

    // Rounding
    gain = 16'sd2048;
    issue(1'b1, 3, -3);
    issue(1'b1, 1, -1);
    idle(4);

    // Fill and overflow with the consumer stalled
    gain      = 16'sd4096;
    dac_ready = 1'b0;
    for (int i = 1; i <= 17; i++) issue(1'b1, i, -i);
    idle(3);
    clr_status = 1'b1;
    idle(1);
    clr_status = 1'b0;

    // Full buffer: one read coinciding with one write keeps level at 16
    issue(1'b1, 100, -100);
    idle(1);
    dac_ready = 1'b1;
    idle(1);
    dac_ready = 1'b0;
    idle(2);
    dac_ready = 1'b1;
    idle(20);

    // Randomized traffic with back-pressure, enable gaps and clears
    for (int n = 0; n < 400; n++) begin
      ENABLE     = ($urandom % 8) != 0;
      dac_ready  = ($urandom % 3) != 0;
      clr_status = ($urandom % 25) == 0;
      case ($urandom % 3)
        0:       gain = 16'sd4096;
        1:       gain = 16'($urandom_range(0, 16383));
        default: gain = 16'($urandom);
      endcase
      issue(($urandom % 4) != 0, int'($urandom), int'($urandom));
    end
    ENABLE     = 1'b1;
    clr_status = 1'b0;
    dac_ready  = 1'b1;
    idle(24);

    // Reset mid-stream: five buffered plus two in flight
    dac_ready = 1'b0;
    gain      = 16'sd8192;
    for (int i = 0; i < 7; i++) issue(1'b1, 20000 + i, -20000 - i);
    rst_n = 1'b0;
    #1;
    chk("async_rst_dac_valid", dac_valid, 0);
    chk("async_rst_fifo_level", fifo_level, 0);
    chk("async_rst_sat_count", sat_count, 0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    dac_ready = 1'b1;
    idle(8);

    chk("issue_queue_drained", iss_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dpd_output_stage.md
# dpd_output_stage

Output conditioning stage placed directly downstream of the DPD top level. It takes the pre-distorted complex sample stream (`y_dpd_re`/`y_dpd_im` qualified by `valid_out`) and applies a programmable real back-off gain with round-half-up and saturation. The result is buffered in a small first-word-fall-through (FWFT) FIFO, so the DAC/upconverter interface can apply ready/valid back-pressure, which the MAC array itself cannot accept. Status outputs report FIFO occupancy, sticky overflow and a saturation event count.

## Interface
- `DATA_WIDTH`, 16: sample width, signed, same Q format as the DPD output.
- `GAIN_WIDTH`, 16: gain width, signed, with `FRAC_SZ` fractional bits.
- `FRAC_SZ`, 12: fractional bits of `gain`.
- `FIFO_AW`, 4: FIFO address width; depth is 2**FIFO_AW (16).
- `SATCNT_WIDTH`, 16: width of the saturation counter.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ENABLE`  in  1  when low, `valid_in` is ignored; the pipeline and FIFO keep draining.
- `valid_in`  in  1  one-cycle strobe per sample, driven by DPD `valid_out`.
- `y_in_re`, `y_in_im`  in  DATA_WIDTH  signed DPD output sample.
- `gain`  in  GAIN_WIDTH  signed back-off gain; sampled together with each accepted sample.
- `clr_status`  in  1  synchronous clear of `overflow` and `sat_count`.
- `dac_ready`  in  1  consumer ready.
- `dac_valid`  out  1  FIFO head valid.
- `dac_re`, `dac_im`  out  DATA_WIDTH  FIFO head sample; forced to 0 while `dac_valid`=0.
- `fifo_full`, `fifo_empty`  out  1  FIFO status flags.
- `fifo_level`  out  FIFO_AW+1  current occupancy, 0..16.
- `overflow`  out  1  sticky; set when a sample is dropped.
- `sat_count`  out  SATCNT_WIDTH  count of saturated samples; saturates at all-ones.

## Operation
- **S1 (multiply):** when `valid_in && ENABLE`, register `p_re = y_in_re*gain` and `p_im = y_in_im*gain`. Products are full width (DATA_WIDTH+GAIN_WIDTH, signed). A valid bit is registered alongside.
- **S2 (scale):**
  - Add 2**(FRAC_SZ-1), then arithmetic shift right by FRAC_SZ.
  - Clamp to [-2**(DATA_WIDTH-1), 2**(DATA_WIDTH-1)-1], i.e. [-32768, 32767].
  - Register the result and valid bit; also register a per-sample `sat` flag (re OR im clamped).
- **sat_count:** incremented by 1 per S2-valid sample with `sat`=1, regardless of whether the FIFO accepts it. It holds at all-ones rather than wrapping.
- **FIFO write:** `wr = s2_valid && (!fifo_full || rd)`, where `rd = dac_valid && dac_ready`.
  - A write while full with no same-cycle read is dropped, and `overflow` is set.
  - A write while full with a same-cycle read is accepted; the level is unchanged.
- **FIFO read:** occurs on `rd`. The FIFO is FWFT: the head is visible combinationally from the memory at `rd_ptr`.
- **Pointers:** FIFO_AW+1 bits wide, wrapping naturally.
  - full = MSBs differ and the lower bits are equal.
  - empty = pointers equal.
  - `fifo_level = wr_ptr - rd_ptr`.
- **clr_status:** clears `overflow` and `sat_count` on the next edge. If it coincides with a new saturation or drop event, the clear wins.
- **ENABLE deassertion mid-stream:** samples already in S1/S2 complete normally; no new samples enter.
- **Status states:** IDLE (empty), STREAM (0 < level < 16) and FULL. These are implicit in the pointers; no explicit FSM register.

## Timing
- Reset values:
  - `dac_valid`=0, `dac_re`=`dac_im`=0.
  - `fifo_empty`=1, `fifo_full`=0, `fifo_level`=0.
  - `overflow`=0, `sat_count`=0.
  - All pipeline valids 0; FIFO memory cleared to 0.
- **Latency:**
  - `valid_in` at edge N → S1 valid after N → S2 valid after N+1 → FIFO write at edge N+2.
  - `dac_valid`=1 in the cycle after edge N+2 (3 cycles when the FIFO is empty).
- **Throughput:** one sample per cycle, with no bubbles in the pipeline.
- **Back-pressure:** `dac_valid` never drops without a read. `dac_re`/`dac_im` are stable while `dac_valid && !dac_ready`.
- **Reset asserted mid-operation:** all state clears immediately and asynchronously; in-flight and buffered samples are discarded.

## Structure
- Shared package `dpd_pkg`:
  - `sat_f` function (round + clamp).
  - Data and gain typedefs for DATA_WIDTH/GAIN_WIDTH.
  - Default FRAC_SZ constant shared with the MAC array.
- One sub-module, `dpd_sync_fifo`:
  - Parameterised width (2*DATA_WIDTH) and FIFO_AW.
  - FWFT, with full/empty/level outputs.
  - Write-when-full-with-read supported.
- The top level holds the S1/S2 pipeline and the status logic.

## Test plan
- **Unity gain passthrough:** `gain`=4096, (1000,-1000) at cycle 0 with `dac_ready`=1 → `dac_valid` at cycle 3 with (1000,-1000); `sat_count`=0.
- **Saturation:** `gain`=8192, inputs (20000,-20000) → output (32767,-32768), `sat_count`=1; a second saturated sample → `sat_count`=2; `clr_status` → 0.
- **Rounding:** `gain`=2048, inputs (3,-3) → (2,-1); inputs (1,-1) → (1,0).
- **Fill and overflow:**
  - `dac_ready`=0, 17 samples 1..17 → `fifo_full`=1, `fifo_level`=16, `overflow`=1.
  - Raising `dac_ready` drains 1..16 in order; `fifo_empty`=1 after.
- **Full with simultaneous read/write:** FIFO full, `dac_ready`=1 for one cycle while a new sample is written → level stays 16, `overflow` stays 0, order preserved.
- **Reset mid-stream:**
  - 5 samples queued plus 2 in the pipeline, then `rst_n` pulse → `dac_valid`=0, `fifo_level`=0, `sat_count`=0 immediately.
  - No stale sample emerges afterwards.
